// File: rtl/poly_stream_dma.sv
// poly_stream_dma: command-driven burst mover between a valid/ready word
// stream and the NTT polynomial memory port. Loads write one LANES-wide
// beat per cycle; unloads issue credit-checked reads into a return FIFO.
module poly_stream_dma #(
  parameter int LOGQ          = 32,
  parameter int LOGN          = 12,
  parameter int NUM_POLY_MEMS = 2,
  parameter int LANES         = 1,
  parameter int IO_RD_LAT     = 4,
  parameter int FIFO_DEPTH    = 8,
  localparam int PW = (NUM_POLY_MEMS > 1) ? $clog2(NUM_POLY_MEMS) : 1,
  localparam int DW = LANES * LOGQ,
  localparam int AW = PW + LOGN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_write,
  input  logic            i_cmd_bitrev,
  input  logic [PW-1:0]   i_cmd_poly,
  input  logic [LOGN-1:0] i_cmd_start,
  input  logic [LOGN:0]   i_cmd_len,
  input  logic            i_s_valid,
  output logic            o_s_ready,
  input  logic [DW-1:0]   i_s_data,
  output logic            o_m_valid,
  input  logic            i_m_ready,
  output logic [DW-1:0]   o_m_data,
  output logic            o_m_last,
  output logic            o_mem_wen,
  output logic [AW-1:0]   o_mem_waddr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [AW-1:0]   o_mem_raddr,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic            o_busy,
  output logic            o_done
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = LOGN + 1;
  localparam logic [LOGN-1:0] STEP  = LOGN'(LANES);
  localparam logic [LOGN-1:0] AMASK = ~(LOGN'(LANES - 1));
  localparam logic [FW:0]     ONE_F = (FW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UNLOAD, S_FINISH} state_t;
  state_t r_state, w_next;

  logic            r_brev;
  logic [PW-1:0]   r_poly;
  logic [CW-1:0]   r_len, r_cnt;
  logic [LOGN-1:0] r_idx;
  logic            r_wen;
  logic [AW-1:0]   r_waddr, r_raddr;
  logic [DW-1:0]   r_wdata;
  logic [IO_RD_LAT:0] r_vld_pipe, r_last_pipe;
  logic [FW:0]     r_inflight, r_fcnt;
  logic [FW-1:0]   r_wp, r_rp;
  logic [DW-1:0]   r_fdata [FIFO_DEPTH];
  logic            r_flast [FIFO_DEPTH];

  logic            w_cmd_hs, w_cmd_brev, w_s_hs, w_credit, w_issue;
  logic            w_first_rd, w_rd_go, w_rd_last, w_push, w_pop;
  logic [CW-1:0]   w_cmd_len;
  logic [LOGN-1:0] w_cmd_start;

  // Coefficient index to memory index, optionally bit-reversed over LOGN bits.
  function automatic logic [LOGN-1:0] f_map(input logic brev, input logic [LOGN-1:0] idx);
    logic [LOGN-1:0] rev;
    for (int b = 0; b < LOGN; b++) rev[b] = idx[LOGN-1-b];
    return brev ? rev : idx;
  endfunction

  assign w_cmd_hs    = i_cmd_valid && (r_state == S_IDLE);
  assign w_cmd_len   = (i_cmd_len == '0) ? CW'(1) : i_cmd_len;
  assign w_cmd_start = i_cmd_start & AMASK;
  assign w_cmd_brev  = i_cmd_bitrev && (LANES == 1);
  assign w_s_hs      = (r_state == S_LOAD) && i_s_valid;
  // Reserve a FIFO slot for every read in flight so returns can never overflow.
  assign w_credit    = ({1'b0, r_fcnt} + {1'b0, r_inflight}) < (FW+2)'(FIFO_DEPTH);
  assign w_issue     = (r_state == S_UNLOAD) && (r_cnt < r_len) && w_credit;
  // The first unload read goes out on the command handshake itself to hit the
  // IO_RD_LAT+1 first-beat latency; the FIFO is always empty at that point.
  assign w_first_rd  = w_cmd_hs && !i_cmd_write;
  assign w_rd_go     = w_first_rd || w_issue;
  assign w_rd_last   = w_first_rd ? (w_cmd_len == CW'(1)) : (r_cnt == r_len - CW'(1));
  assign w_push      = r_vld_pipe[IO_RD_LAT];
  assign w_pop       = o_m_valid && i_m_ready;

  assign o_m_valid   = (r_fcnt != '0);
  assign o_m_data    = o_m_valid ? r_fdata[r_rp] : '0;
  assign o_m_last    = o_m_valid && r_flast[r_rp];
  assign o_mem_wen   = r_wen;
  assign o_mem_waddr = r_waddr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_raddr = r_raddr;
  assign o_busy      = ~o_cmd_ready;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_next      = r_state;
    o_cmd_ready = 1'b0;
    o_s_ready   = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (w_cmd_hs) w_next = i_cmd_write ? S_LOAD : S_UNLOAD;
      end
      S_LOAD: begin
        o_s_ready = 1'b1;
        if (w_s_hs && (r_cnt == r_len - CW'(1))) w_next = S_FINISH;
      end
      S_UNLOAD: if (w_pop && o_m_last) w_next = S_FINISH;
      S_FINISH: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, address walk, write port and read issue.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_brev      <= 1'b0;
      r_poly      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_raddr     <= '0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_inflight  <= '0;
    end else begin
      r_wen <= w_s_hs;
      if (w_cmd_hs) begin
        r_brev <= w_cmd_brev;
        r_poly <= i_cmd_poly;
        r_len  <= w_cmd_len;
        r_idx  <= i_cmd_write ? w_cmd_start : w_cmd_start + STEP;
        r_cnt  <= i_cmd_write ? '0 : CW'(1);
      end else if (w_s_hs || w_issue) begin
        r_idx <= r_idx + STEP;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_s_hs) begin
        r_waddr <= {r_poly, f_map(r_brev, r_idx)};
        r_wdata <= i_s_data;
      end
      if (w_first_rd)   r_raddr <= {i_cmd_poly, f_map(w_cmd_brev, w_cmd_start)};
      else if (w_issue) r_raddr <= {r_poly, f_map(r_brev, r_idx)};
      r_vld_pipe  <= {r_vld_pipe[IO_RD_LAT-1:0], w_rd_go};
      r_last_pipe <= {r_last_pipe[IO_RD_LAT-1:0], w_rd_go && w_rd_last};
      if (w_rd_go && !w_push)      r_inflight <= r_inflight + ONE_F;
      else if (!w_rd_go && w_push) r_inflight <= r_inflight - ONE_F;
    end
  end

  // Return FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + FW'(1);
      if (w_pop)  r_rp <= r_rp + FW'(1);
      if (w_push && !w_pop)      r_fcnt <= r_fcnt + ONE_F;
      else if (!w_push && w_pop) r_fcnt <= r_fcnt - ONE_F;
    end
  end

  // Return FIFO storage; contents are only visible while occupancy is non-zero.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fdata[r_wp] <= i_mem_rdata;
      r_flast[r_wp] <= r_last_pipe[IO_RD_LAT];
    end
  end
endmodule

// File: tb/tb_poly_stream_dma.sv
// Bench for poly_stream_dma: a LANES=1 instance (N=16) driven with directed
// and random bursts against an index-arithmetic model, plus a LANES=4 instance.
module tb_poly_stream_dma;
  localparam int LOGN = 4, N = 16, LAT_A = 4, DEP_A = 8, LAT_B = 2, DEP_B = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {logic [4:0] a; logic [127:0] d; logic l; int c;} ev_t;

  // ---------------- instance A: LANES=1 ----------------
  logic a_cmd_valid = 0, a_cmd_ready, a_cmd_write = 0, a_cmd_bitrev = 0;
  logic [0:0] a_cmd_poly = 0;
  logic [3:0] a_cmd_start = 0;
  logic [4:0] a_cmd_len = 0;
  logic a_s_valid = 0, a_s_ready, a_m_valid, a_m_ready = 0, a_m_last, a_mem_wen, a_busy, a_done;
  logic [31:0] a_s_data = 0, a_m_data, a_mem_wdata, a_mem_rdata;
  logic [4:0] a_mem_waddr, a_mem_raddr;

  poly_stream_dma #(.LOGQ(32), .LOGN(LOGN), .NUM_POLY_MEMS(2), .LANES(1),
                    .IO_RD_LAT(LAT_A), .FIFO_DEPTH(DEP_A)) u_a (
    .i_clk(clk), .i_rst(rst_n), .i_cmd_valid(a_cmd_valid), .o_cmd_ready(a_cmd_ready),
    .i_cmd_write(a_cmd_write), .i_cmd_bitrev(a_cmd_bitrev), .i_cmd_poly(a_cmd_poly),
    .i_cmd_start(a_cmd_start), .i_cmd_len(a_cmd_len), .i_s_valid(a_s_valid),
    .o_s_ready(a_s_ready), .i_s_data(a_s_data), .o_m_valid(a_m_valid), .i_m_ready(a_m_ready),
    .o_m_data(a_m_data), .o_m_last(a_m_last), .o_mem_wen(a_mem_wen), .o_mem_waddr(a_mem_waddr),
    .o_mem_wdata(a_mem_wdata), .o_mem_raddr(a_mem_raddr), .i_mem_rdata(a_mem_rdata),
    .o_busy(a_busy), .o_done(a_done));

  logic [31:0] mem_a [32];
  logic [4:0]  rh_a [LAT_A];
  always @(posedge clk) begin
    if (a_mem_wen) mem_a[a_mem_waddr] <= a_mem_wdata;
    rh_a[0] <= a_mem_raddr;
    for (int i = 1; i < LAT_A; i++) rh_a[i] <= rh_a[i-1];
  end
  assign a_mem_rdata = mem_a[rh_a[LAT_A-1]];

  ev_t a_wq[$], a_rq[$];
  int a_done_cnt = 0, a_done_cyc = 0, rdy_mode = 0;
  logic a_prev_stall = 0;
  logic [31:0] a_prev_data = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (a_mem_wen) a_wq.push_back('{a_mem_waddr, 128'(a_mem_wdata), 1'b0, cyc});
      if (a_m_valid && a_m_ready) a_rq.push_back('{5'd0, 128'(a_m_data), a_m_last, cyc});
      if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
      if (a_prev_stall) begin
        chk("stall_hold_valid", 128'(a_m_valid), 128'(1));
        chk("stall_hold_data", 128'(a_m_data), 128'(a_prev_data));
      end
      a_prev_stall = a_m_valid && !a_m_ready;
      a_prev_data  = a_m_data;
    end else a_prev_stall = 0;
  end

  initial forever begin
    @(posedge clk); #2;
    case (rdy_mode)
      0: a_m_ready = 1'b1;
      1: a_m_ready = (cyc % 3 == 0);
      2: a_m_ready = 1'($urandom_range(0, 1));
      default: a_m_ready = 1'b0;
    endcase
  end

  // Reference model: coefficient index of beat k, straight from the addressing rule.
  logic [31:0] ref_a [32];
  function automatic int exp_idx(int st, int k, int lanes, logic br);
    int idx, r;
    idx = ((st / lanes) * lanes + k * lanes) % N;
    if (br && lanes == 1) begin
      r = 0;
      for (int b = 0; b < LOGN; b++) if (((idx >> b) & 1) == 1) r += 1 << (LOGN - 1 - b);
      idx = r;
    end
    return idx;
  endfunction

  task automatic a_cmd(input logic w, input logic br, input logic [0:0] p, input logic [3:0] st,
                       input logic [4:0] ln, output int hs);
    int g = 0;
    @(negedge clk);
    a_cmd_valid = 1; a_cmd_write = w; a_cmd_bitrev = br; a_cmd_poly = p;
    a_cmd_start = st; a_cmd_len = ln;
    #1;
    while (!a_cmd_ready && g < 200) begin @(negedge clk); #1; g++; end
    if (g >= 200) chk("cmd_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    hs = cyc;
    a_cmd_valid = 0;
  endtask

  task automatic a_load(input logic br, input logic [0:0] p, input int st, input int ln,
                        input logic seq, input string tag);
    int hs, k = 0, g = 0, last_hs = 0, d0 = a_done_cnt, n, ix;
    logic hsk;
    logic [31:0] dat [16];
    n = (ln == 0) ? 1 : ln;
    for (int i = 0; i < 16; i++) dat[i] = seq ? 32'(100 + i) : $urandom;
    a_wq.delete();
    a_cmd(1'b1, br, p, 4'(st), 5'(ln), hs);
    while (k < n && g < 2000) begin
      @(negedge clk);
      a_s_valid = ($urandom_range(0, 3) != 0); a_s_data = dat[k];
      #1 hsk = a_s_valid && a_s_ready;
      @(posedge clk); #1;
      if (hsk) begin k++; last_hs = cyc; end
      g++;
    end
    a_s_valid = 0;
    if (g >= 2000) chk({tag, "_beat_timeout"}, 128'(k), 128'(n));
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_done_cnt"}, 128'(a_done_cnt - d0), 128'(1));
    chk({tag, "_done_cyc"}, 128'(a_done_cyc), 128'(last_hs));
    chk({tag, "_nwr"}, 128'(a_wq.size()), 128'(n));
    for (int i = 0; i < n && i < a_wq.size(); i++) begin
      ix = p * N + exp_idx(st, i, 1, br);
      chk({tag, "_waddr"}, 128'(a_wq[i].a), 128'(ix));
      chk({tag, "_wdata"}, a_wq[i].d, 128'(dat[i]));
      ref_a[ix] = dat[i];
    end
  endtask

  task automatic a_unload(input logic br, input logic [0:0] p, input int st, input int ln,
                          input int mode, input string tag);
    int hs, g = 0, d0 = a_done_cnt, n;
    n = (ln == 0) ? 1 : ln;
    rdy_mode = mode;
    a_rq.delete();
    a_cmd(1'b0, br, p, 4'(st), 5'(ln), hs);
    while (a_done_cnt == d0 && g < 1000) begin @(negedge clk); #1; g++; end
    if (g >= 1000) chk({tag, "_done_timeout"}, 128'(g), 128'(0));
    chk({tag, "_nbeats"}, 128'(a_rq.size()), 128'(n));
    for (int i = 0; i < n && i < a_rq.size(); i++) begin
      chk({tag, "_mdata"}, a_rq[i].d, 128'(ref_a[p * N + exp_idx(st, i, 1, br)]));
      chk({tag, "_mlast"}, 128'(a_rq[i].l), 128'(i == n - 1));
    end
    if (mode == 0 && a_rq.size() == n) begin
      chk({tag, "_first_lat"}, 128'(a_rq[0].c - hs), 128'(LAT_A + 1));
      chk({tag, "_b2b"}, 128'(a_rq[n-1].c - a_rq[0].c), 128'(n - 1));
    end
  endtask

  // ---------------- instance B: LANES=4 ----------------
  logic b_cmd_valid = 0, b_cmd_ready, b_cmd_write = 0;
  logic [0:0] b_cmd_poly = 0;
  logic [3:0] b_cmd_start = 0;
  logic [4:0] b_cmd_len = 0;
  logic b_s_valid = 0, b_s_ready, b_m_valid, b_m_last, b_mem_wen, b_busy, b_done;
  logic [127:0] b_s_data = 0, b_m_data, b_mem_wdata, b_mem_rdata;
  logic [4:0] b_mem_waddr, b_mem_raddr;

  poly_stream_dma #(.LOGQ(32), .LOGN(LOGN), .NUM_POLY_MEMS(2), .LANES(4),
                    .IO_RD_LAT(LAT_B), .FIFO_DEPTH(DEP_B)) u_b (
    .i_clk(clk), .i_rst(rst_n), .i_cmd_valid(b_cmd_valid), .o_cmd_ready(b_cmd_ready),
    .i_cmd_write(b_cmd_write), .i_cmd_bitrev(1'b0), .i_cmd_poly(b_cmd_poly),
    .i_cmd_start(b_cmd_start), .i_cmd_len(b_cmd_len), .i_s_valid(b_s_valid),
    .o_s_ready(b_s_ready), .i_s_data(b_s_data), .o_m_valid(b_m_valid), .i_m_ready(1'b1),
    .o_m_data(b_m_data), .o_m_last(b_m_last), .o_mem_wen(b_mem_wen), .o_mem_waddr(b_mem_waddr),
    .o_mem_wdata(b_mem_wdata), .o_mem_raddr(b_mem_raddr), .i_mem_rdata(b_mem_rdata),
    .o_busy(b_busy), .o_done(b_done));

  logic [127:0] mem_b [32];
  logic [4:0]   rh_b [LAT_B];
  always @(posedge clk) begin
    if (b_mem_wen) mem_b[b_mem_waddr] <= b_mem_wdata;
    rh_b[0] <= b_mem_raddr;
    for (int i = 1; i < LAT_B; i++) rh_b[i] <= rh_b[i-1];
  end
  assign b_mem_rdata = mem_b[rh_b[LAT_B-1]];

  ev_t b_wq[$], b_rq[$];
  int b_done_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (b_mem_wen) b_wq.push_back('{b_mem_waddr, b_mem_wdata, 1'b0, cyc});
      if (b_m_valid) b_rq.push_back('{5'd0, b_m_data, b_m_last, cyc});
      if (b_done) b_done_cnt++;
    end
  end

  task automatic b_cmd(input logic w, input logic [3:0] st, input logic [4:0] ln);
    @(negedge clk);
    b_cmd_valid = 1; b_cmd_write = w; b_cmd_poly = 0; b_cmd_start = st; b_cmd_len = ln;
    @(posedge clk); #1;
    b_cmd_valid = 0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    int hs, d0, g, st, ln;
    logic [0:0] p;
    logic br;
    logic [127:0] bd [2];

    #1;
    chk("rst_cmd_ready", 128'(a_cmd_ready), 128'(1));
    chk("rst_busy", 128'(a_busy), 128'(0));
    chk("rst_done", 128'(a_done), 128'(0));
    chk("rst_s_ready", 128'(a_s_ready), 128'(0));
    chk("rst_m_valid", 128'(a_m_valid), 128'(0));
    chk("rst_m_data", 128'(a_m_data), 128'(0));
    chk("rst_mem_wen", 128'(a_mem_wen), 128'(0));
    chk("rst_raddr", 128'(a_mem_raddr), 128'(0));
    chk("rst_b_cmd_ready", 128'(b_cmd_ready), 128'(1));
    repeat (3) @(negedge clk);
    rst_n = 1;

    // full-poly load and unload of poly 1
    a_load(1'b0, 1'b1, 0, 16, 1'b1, "t1_load");
    a_unload(1'b0, 1'b1, 0, 16, 0, "t2_unload");
    a_unload(1'b0, 1'b1, 0, 16, 1, "t3_bp");

    // wrap inside a polynomial, then bit-reversed ordering
    a_load(1'b0, 1'b0, 14, 4, 1'b0, "t4_wrap");
    chk("t4_wrap_addr2", 128'(a_wq[2].a), 128'(0));
    a_unload(1'b0, 1'b0, 14, 4, 2, "t4_wrap_ul");
    a_load(1'b1, 1'b0, 1, 2, 1'b0, "t4_brev");
    chk("t4_brev_addr0", 128'(a_wq[0].a), 128'(8));
    chk("t4_brev_addr1", 128'(a_wq[1].a), 128'(4));
    a_unload(1'b1, 1'b0, 1, 2, 0, "t4_brev_ul");

    // random bursts, len 0 included
    for (int it = 0; it < 8; it++) begin
      p = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 15); ln = $urandom_range(0, 16);
      a_load(br, p, st, ln, 1'b0, "rnd_load");
      a_unload(br, p, st, ln, $urandom_range(0, 2), "rnd_unload");
    end

    // LANES=4: start 6 aligns down to 4
    bd[0] = {$urandom, $urandom, $urandom, $urandom};
    bd[1] = {$urandom, $urandom, $urandom, $urandom};
    b_wq.delete(); d0 = b_done_cnt;
    b_cmd(1'b1, 4'd6, 5'd2);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); b_s_valid = 1; b_s_data = bd[k];
    end
    @(negedge clk); b_s_valid = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_nwr", 128'(b_wq.size()), 128'(2));
    chk("t5_done", 128'(b_done_cnt - d0), 128'(1));
    if (b_wq.size() == 2) begin
      chk("t5_waddr0", 128'(b_wq[0].a), 128'(4));
      chk("t5_waddr1", 128'(b_wq[1].a), 128'(8));
      chk("t5_wdata0", b_wq[0].d, bd[0]);
      chk("t5_wdata1", b_wq[1].d, bd[1]);
    end
    b_rq.delete();
    b_cmd(1'b0, 4'd5, 5'd2);
    g = 0;
    while (b_rq.size() < 2 && g < 100) begin @(negedge clk); #1; g++; end
    chk("t5_nbeats", 128'(b_rq.size()), 128'(2));
    if (b_rq.size() == 2) begin
      chk("t5_mdata0", b_rq[0].d, bd[0]);
      chk("t5_mdata1", b_rq[1].d, bd[1]);
      chk("t5_mlast1", 128'(b_rq[1].l), 128'(1));
    end
    repeat (3) @(negedge clk);

    // reset in the middle of a stalled unload
    d0 = a_done_cnt;
    rdy_mode = 3;
    a_cmd(1'b0, 1'b0, 1'b1, 4'd0, 5'd16, hs);
    repeat (8) @(negedge clk);
    #1;
    chk("t6_pre_mvalid", 128'(a_m_valid), 128'(1));
    rst_n = 0;
    #1;
    chk("t6_mvalid", 128'(a_m_valid), 128'(0));
    chk("t6_cmd_ready", 128'(a_cmd_ready), 128'(1));
    chk("t6_busy", 128'(a_busy), 128'(0));
    chk("t6_done", 128'(a_done), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_no_done", 128'(a_done_cnt), 128'(d0));
    a_unload(1'b0, 1'b1, 2, 4, 0, "t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
